// File: rtl/imem_loader.sv
// Program loader: packs a byte stream into 16-bit instruction words
// (high byte first) and writes them into instruction memory from word 0,
// holding the CPU stalled until the halt word lands or memory fills up.
module imem_loader #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [15:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W:0]   word_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HIGH,
    S_LOW,
    S_WRITE,
    S_DONE
  } state_t;

  // Word count at which memory is full; one extra bit so DEPTH itself fits.
  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [15:0]     HALT_WORD = 16'hFFFF;

  state_t            state;
  state_t            next_state;
  logic [7:0]        high_byte;
  logic [ADDR_W:0]   count_next;
  logic              is_halt;
  logic              is_last;

  assign count_next = word_count + 1'b1;
  assign is_halt    = (mem_wdata == HALT_WORD);
  assign is_last    = (count_next == DEPTH_CNT);

  // State register; reset abandons any partial word and returns to IDLE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and Moore output decode; handshake outputs depend on state only.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    mem_we     = 1'b0;
    cpu_hold   = 1'b1;
    done       = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) next_state = S_HIGH;
      end
      S_HIGH: begin
        in_ready = 1'b1;
        if (in_valid) next_state = S_LOW;
      end
      S_LOW: begin
        in_ready = 1'b1;
        if (in_valid) next_state = S_WRITE;
      end
      S_WRITE: begin
        mem_we = 1'b1;
        if (is_halt || is_last) next_state = S_DONE;
        else                    next_state = S_HIGH;
      end
      S_DONE: begin
        cpu_hold = 1'b0;
        done     = 1'b1;
        if (start) next_state = S_HIGH;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // Datapath: byte packing, write address/data and load bookkeeping.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      high_byte  <= '0;
      mem_waddr  <= '0;
      mem_wdata  <= '0;
      overflow   <= 1'b0;
      word_count <= '0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            word_count <= '0;
            mem_waddr  <= '0;
            overflow   <= 1'b0;
          end
        end
        S_HIGH: begin
          if (in_valid) high_byte <= in_data;
        end
        S_LOW: begin
          if (in_valid) mem_wdata <= {high_byte, in_data};
        end
        S_WRITE: begin
          word_count <= count_next;
          if (!is_halt) begin
            if (is_last) overflow  <= 1'b1;
            else         mem_waddr <= mem_waddr + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader: a full-size instance covers
// normal loads, backpressure, reset and restart; a DEPTH=4 instance covers overflow.
module tb_imem_loader;

  logic        clock;
  logic        reset;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        sel;

  logic        start_a, valid_a, ready_a, we_a, hold_a, done_a, ovf_a;
  logic [9:0]  waddr_a;
  logic [15:0] wdata_a;
  logic [10:0] wc_a;

  logic        start_b, valid_b, ready_b, we_b, hold_b, done_b, ovf_b;
  logic [1:0]  waddr_b;
  logic [15:0] wdata_b;
  logic [2:0]  wc_b;

  logic        cur_ready;

  logic [31:0] wq_a[$];
  logic [31:0] wq_b[$];

  int n_checks = 0;
  int n_fail   = 0;
  bit ok;

  assign start_a   = start & ~sel;
  assign valid_a   = in_valid & ~sel;
  assign start_b   = start & sel;
  assign valid_b   = in_valid & sel;
  assign cur_ready = sel ? ready_b : ready_a;

  imem_loader dut_a (
    .clock(clock), .reset(reset), .start(start_a), .in_data(in_data),
    .in_valid(valid_a), .in_ready(ready_a), .mem_we(we_a),
    .mem_waddr(waddr_a), .mem_wdata(wdata_a), .cpu_hold(hold_a),
    .done(done_a), .overflow(ovf_a), .word_count(wc_a)
  );

  imem_loader #(.ADDR_W(2), .DEPTH(4)) dut_b (
    .clock(clock), .reset(reset), .start(start_b), .in_data(in_data),
    .in_valid(valid_b), .in_ready(ready_b), .mem_we(we_b),
    .mem_waddr(waddr_b), .mem_wdata(wdata_b), .cpu_hold(hold_b),
    .done(done_b), .overflow(ovf_b), .word_count(wc_b)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Memory model: record every word each instance writes, sampled mid-cycle.
  always @(negedge clock) begin
    if (we_a) wq_a.push_back({6'd0, waddr_a, wdata_a});
    if (we_b) wq_b.push_back({14'd0, waddr_b, wdata_b});
  end

  function automatic logic [31:0] wr(input int addr, input logic [15:0] data);
    return {addr[15:0], data};
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents one byte and waits (bounded) for it to be taken; call at a negedge.
  task automatic send_byte(input logic [7:0] b, input int gap, output bit taken);
    bit fin;
    taken    = 1'b0;
    fin      = 1'b0;
    in_data  = b;
    in_valid = 1'b1;
    for (int i = 0; i < 20 && !fin; i++) begin
      if (cur_ready) begin
        taken = 1'b1;
        fin   = 1'b1;
      end
      @(negedge clock);
    end
    in_valid = 1'b0;
    repeat (gap) @(negedge clock);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    in_data  = 8'h00;
    in_valid = 1'b0;
    sel      = 1'b0;
    repeat (2) @(negedge clock);

    // Reset values
    check_output("rst in_ready", ready_a, 0);
    check_output("rst mem_we", we_a, 0);
    check_output("rst waddr", waddr_a, 0);
    check_output("rst wdata", wdata_a, 0);
    check_output("rst cpu_hold", hold_a, 1);
    check_output("rst done", done_a, 0);
    check_output("rst overflow", ovf_a, 0);
    check_output("rst word_count", wc_a, 0);
    check_output("rst b cpu_hold", hold_b, 1);
    reset = 1'b0;
    @(negedge clock);
    check_output("idle in_ready", ready_a, 0);

    // Basic load with in_valid held high
    pulse_start();
    check_output("t1 high in_ready", ready_a, 1);
    send_byte(8'h70, 0, ok); check_output("t1 take 70", ok, 1);
    send_byte(8'h0F, 0, ok); check_output("t1 take 0F", ok, 1);
    check_output("t1 latency mem_we", we_a, 1);
    check_output("t1 latency waddr", waddr_a, 0);
    check_output("t1 latency wdata", wdata_a, 32'h700F);
    check_output("t1 write in_ready", ready_a, 0);
    send_byte(8'h72, 0, ok);
    send_byte(8'h07, 0, ok);
    send_byte(8'hFF, 0, ok);
    send_byte(8'hFF, 0, ok); check_output("t1 take last", ok, 1);
    repeat (2) @(negedge clock);
    check_output("t1 nwrites", wq_a.size(), 3);
    check_output("t1 w0", wq_a[0], wr(0, 16'h700F));
    check_output("t1 w1", wq_a[1], wr(1, 16'h7207));
    check_output("t1 w2", wq_a[2], wr(2, 16'hFFFF));
    check_output("t1 done", done_a, 1);
    check_output("t1 cpu_hold", hold_a, 0);
    check_output("t1 word_count", wc_a, 3);
    check_output("t1 overflow", ovf_a, 0);
    check_output("t1 idle mem_we", we_a, 0);

    // Backpressure, with a byte offered during WRITE
    wq_a.delete();
    pulse_start();
    check_output("t2 restart cpu_hold", hold_a, 1);
    check_output("t2 restart done", done_a, 0);
    check_output("t2 restart word_count", wc_a, 0);
    send_byte(8'h70, 2, ok);
    send_byte(8'h0F, 0, ok);
    check_output("t2 write in_ready", ready_a, 0);
    send_byte(8'h72, 2, ok); check_output("t2 take 72", ok, 1);
    send_byte(8'h07, 2, ok);
    send_byte(8'hFF, 2, ok);
    send_byte(8'hFF, 2, ok);
    check_output("t2 nwrites", wq_a.size(), 3);
    check_output("t2 w0", wq_a[0], wr(0, 16'h700F));
    check_output("t2 w1", wq_a[1], wr(1, 16'h7207));
    check_output("t2 w2", wq_a[2], wr(2, 16'hFFFF));
    check_output("t2 done", done_a, 1);
    check_output("t2 word_count", wc_a, 3);

    // Overflow on the DEPTH=4 instance
    sel = 1'b1;
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      send_byte(8'(i + 1), 0, ok);
      check_output("t3 take", ok, 1);
    end
    send_byte(8'h09, 0, ok);
    check_output("t3 fifth word refused", ok, 0);
    check_output("t3 nwrites", wq_b.size(), 4);
    check_output("t3 w0", wq_b[0], wr(0, 16'h0102));
    check_output("t3 w1", wq_b[1], wr(1, 16'h0304));
    check_output("t3 w2", wq_b[2], wr(2, 16'h0506));
    check_output("t3 w3", wq_b[3], wr(3, 16'h0708));
    check_output("t3 overflow", ovf_b, 1);
    check_output("t3 done", done_b, 1);
    check_output("t3 word_count", wc_b, 4);
    check_output("t3 waddr no wrap", waddr_b, 3);
    check_output("t3 cpu_hold", hold_b, 0);
    sel = 1'b0;

    // Reset mid-word
    wq_a.delete();
    pulse_start();
    send_byte(8'hAB, 0, ok);
    #2 reset = 1'b1;
    #1;
    check_output("t4 in_ready", ready_a, 0);
    check_output("t4 mem_we", we_a, 0);
    check_output("t4 waddr", waddr_a, 0);
    check_output("t4 wdata", wdata_a, 0);
    check_output("t4 cpu_hold", hold_a, 1);
    check_output("t4 done", done_a, 0);
    check_output("t4 overflow", ovf_a, 0);
    check_output("t4 word_count", wc_a, 0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check_output("t4 no write", wq_a.size(), 0);
    pulse_start();
    send_byte(8'h00, 0, ok);
    send_byte(8'h01, 0, ok);
    send_byte(8'hFF, 0, ok);
    send_byte(8'hFF, 0, ok);
    repeat (2) @(negedge clock);
    check_output("t4 nwrites", wq_a.size(), 2);
    check_output("t4 w0", wq_a[0], wr(0, 16'h0001));
    check_output("t4 w1", wq_a[1], wr(1, 16'hFFFF));
    check_output("t4 word_count", wc_a, 2);

    // Start handling: ignored in LOW, honoured in DONE
    wq_a.delete();
    check_output("t5 pre cpu_hold", hold_a, 0);
    pulse_start();
    check_output("t5 start cpu_hold", hold_a, 1);
    send_byte(8'h12, 0, ok);
    pulse_start();
    send_byte(8'h34, 0, ok);
    send_byte(8'hFF, 0, ok);
    send_byte(8'hFF, 0, ok);
    repeat (2) @(negedge clock);
    check_output("t5 nwrites", wq_a.size(), 2);
    check_output("t5 w0", wq_a[0], wr(0, 16'h1234));
    check_output("t5 w1", wq_a[1], wr(1, 16'hFFFF));
    check_output("t5 word_count", wc_a, 2);
    check_output("t5 done", done_a, 1);

    // Halt as the very first word
    wq_a.delete();
    pulse_start();
    send_byte(8'hFF, 0, ok);
    send_byte(8'hFF, 0, ok);
    repeat (2) @(negedge clock);
    check_output("t6 nwrites", wq_a.size(), 1);
    check_output("t6 w0", wq_a[0], wr(0, 16'hFFFF));
    check_output("t6 done", done_a, 1);
    check_output("t6 word_count", wc_a, 1);
    check_output("t6 overflow", ovf_a, 0);
    check_output("t6 cpu_hold", hold_a, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Program loader: the write side of the instruction memory that the CPU fetch path only reads.
- Accepts a byte stream over a valid/ready handshake.
- Packs byte pairs into 16-bit instruction words, high byte first, and writes them to the instruction memory write port at consecutive word addresses from 0.
- Holds the CPU stalled until the halt word 16'hFFFF has been written or the memory is full.

Parameters:
ADDR_W, 10, width of the word address into instruction memory
DEPTH, 1024, number of 16-bit words in instruction memory; must be less than or equal to 2**ADDR_W

Ports:
clock  input  1  system clock; all state changes on posedge clock
reset  input  1  asynchronous, active-high reset
start  input  1  single-cycle pulse that begins a load; honoured only in IDLE or DONE
in_data  input  8  stream byte
in_valid  input  1  in_data is valid this cycle
in_ready  output  1  loader accepts a byte this cycle; transfer occurs when in_valid and in_ready are both 1 at posedge
mem_we  output  1  instruction memory write enable, one cycle per word
mem_waddr  output  ADDR_W  word address, i.e. byte address >> 1
mem_wdata  output  16  instruction word {high byte, low byte}
cpu_hold  output  1  1 = CPU PC update must be stalled
done  output  1  load complete
overflow  output  1  memory filled before the halt word arrived
word_count  output  ADDR_W+1  words written in the current load, halt word included

Behaviour:
- Reset, asynchronous and active-high, forces these values immediately:
  - state IDLE
  - in_ready=0, mem_we=0, mem_waddr=0, mem_wdata=0
  - cpu_hold=1, done=0, overflow=0, word_count=0
  - internal high-byte register = 0
- All outputs are registered or decoded from state only (Moore); none is combinational from in_valid or in_data.
- States: IDLE, HIGH, LOW, WRITE, DONE.
- IDLE:
  - in_ready=0, cpu_hold=1.
  - start=1 moves to HIGH and clears word_count, mem_waddr, overflow and done.
- HIGH:
  - in_ready=1.
  - On handshake, latch in_data as the high byte and go to LOW.
  - With no handshake, stay in HIGH; gaps of any length are legal.
- LOW:
  - in_ready=1.
  - On handshake, mem_wdata <= {high byte, in_data} and go to WRITE.
- WRITE, exactly one cycle:
  - mem_we=1, in_ready=0.
  - mem_waddr = word_count[ADDR_W-1:0].
  - Memory captures the word at this posedge.
  - Next-state priority:
    - mem_wdata==16'hFFFF: word_count+1, go to DONE, overflow stays 0.
    - else if word_count+1==DEPTH: word_count=DEPTH, overflow <= 1, go to DONE.
    - else: word_count+1, mem_waddr+1, go to HIGH.
- DONE:
  - in_ready=0, mem_we=0, done=1.
  - cpu_hold=0 in the same cycle done rises.
  - start=1 re-enters HIGH with the counters cleared, and cpu_hold returns to 1 on that edge.
- start in HIGH, LOW or WRITE is ignored; a load cannot be restarted mid-word.
- Latency and throughput:
  - Write occurs in the cycle after the low byte is accepted.
  - Peak rate is one word per 3 cycles.
- The halt word is written to memory, so the CPU fetches it and halts normally.
- mem_wdata and mem_waddr hold their last values outside WRITE; only mem_we qualifies them.
- No wrap-around: mem_waddr never exceeds DEPTH-1, and no write occurs after DONE.
- A reset mid-load abandons the partial word. Words already written stay in memory, but all loader state and outputs return to reset values.
- A byte presented while in_ready=0 is not consumed; the source must hold it until accepted.

Test Plan:
- Basic load: reset, start, then stream 70 0F 72 07 FF FF with in_valid held high -> exactly three mem_we pulses:
  - addr0=16'h700F, addr1=16'h7207, addr2=16'hFFFF
  - done=1, cpu_hold=0, word_count=3, overflow=0
- Backpressure: same stream with in_valid deasserted 2 cycles between every byte, plus a byte presented during WRITE -> identical writes and final state; the byte offered during WRITE is accepted only in the following HIGH.
- Overflow: DEPTH=4, stream 5 words with no FFFF -> 4 writes at addresses 0..3, overflow=1, done=1, word_count=4; the fifth word's bytes are never accepted.
- Reset mid-word: assert reset one cycle after the high byte handshake -> all outputs at reset values immediately, with no mem_we. Then start and load 00 01 FF FF -> writes addr0=16'h0001, addr1=16'hFFFF.
- Start handling: a start pulse while in LOW has no effect. After DONE, start then stream 12 34 FF FF -> cpu_hold rises on the start edge; writes addr0=16'h1234, addr1=16'hFFFF; word_count=2.
- Halt as first word: start, then FF FF -> one write at addr0 of 16'hFFFF, done=1, word_count=1.
